// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : lcd_cmd_sequencer
// Purpose  : FIFO-buffered {RS,DATA} word issuer for the character-LCD bus
//            controller, with HD44780 post-command hold-off timing.
//            Optional power-on init sequence: define LCD_POWERUP_INIT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module lcd_cmd_sequencer #(
    parameter int DEPTH       = 16,
    parameter int SHORT_DLY   = 2000,
    parameter int LONG_DLY    = 82000,
    parameter int POWERUP_DLY = 750000,
    parameter int DLY_W       = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [8:0]                 wr_data,
    output logic                       wr_ready,
    output logic [7:0]                 lcd_data,
    output logic                       lcd_rs,
    output logic                       lcd_start,
    input  logic                       lcd_done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = $clog2(DEPTH);

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [DLY_W-1:0]   c_short_m1 = DLY_W'(SHORT_DLY - 1);
    localparam logic [DLY_W-1:0]   c_long_m1  = DLY_W'(LONG_DLY - 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            SHORT_DLY < 1 || LONG_DLY < 1 || POWERUP_DLY < 1 ||
            longint'(SHORT_DLY)   >= (64'd1 << DLY_W) ||
            longint'(LONG_DLY)    >= (64'd1 << DLY_W) ||
            longint'(POWERUP_DLY) >= (64'd1 << DLY_W)) begin : g_bad_param
            $error("lcd_cmd_sequencer: illegal DEPTH or delay/DLY_W combination");
        end
    endgenerate

`ifdef LCD_POWERUP_INIT_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELAY     = 3'd4,
        ST_PWR_WAIT  = 3'd5
    } state_t;

    localparam state_t           c_rst_state = ST_PWR_WAIT;
    localparam logic [DLY_W-1:0] c_rst_dly   = DLY_W'(POWERUP_DLY - 1);
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELAY     = 3'd4
    } state_t;

    localparam state_t           c_rst_state = ST_IDLE;
    localparam logic [DLY_W-1:0] c_rst_dly   = '0;
`endif

    state_t               r_state;
    state_t               w_state_nxt;

    logic [8:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [DLY_W-1:0]     r_dly;
    logic [7:0]           r_lcd_data;
    logic                 r_lcd_rs;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_is_long;
    logic                 w_init_active;
    logic [8:0]           w_head;
    logic [8:0]           w_issue_word;

    assign w_head = r_mem[r_rd_ptr];

`ifdef LCD_POWERUP_INIT_EN
    // Index 0..3 selects the ROM word to issue next; 4 means init finished.
    logic [2:0] r_init_idx;
    logic [8:0] w_rom_word;

    assign w_init_active = (r_init_idx != 3'd4);

    always_comb begin
        w_rom_word = 9'h038;
        case (r_init_idx[1:0])
            2'd0:    w_rom_word = 9'h038;
            2'd1:    w_rom_word = 9'h00C;
            2'd2:    w_rom_word = 9'h001;
            default: w_rom_word = 9'h006;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_init_idx <= 3'd0;
        end else if (w_issue && w_init_active) begin
            r_init_idx <= r_init_idx + 3'd1;
        end
    end

    assign w_issue_word = w_init_active ? w_rom_word : w_head;
`else
    assign w_init_active = 1'b0;
    assign w_issue_word  = w_head;
`endif

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign w_is_long = !r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data[1:0] != 2'd0);

    assign wr_ready = (r_count < c_depth);
    assign w_push   = wr_valid && wr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_init_active || (r_count != '0)) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_init_active || (r_count != '0)) begin
                    w_issue     = 1'b1;
                    w_pop       = !w_init_active;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (lcd_done) begin
                    w_state_nxt = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_dly == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef LCD_POWERUP_INIT_EN
            ST_PWR_WAIT: begin
                if (r_dly == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lcd_data <= 8'd0;
            r_lcd_rs   <= 1'b0;
        end else if (w_issue) begin
            r_lcd_rs   <= w_issue_word[8];
            r_lcd_data <= w_issue_word[7:0];
        end
    end

    // Loaded with N-1 so that the hold-off state lasts exactly N cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dly <= c_rst_dly;
        end else if ((r_state == ST_WAIT_DONE) && lcd_done) begin
            r_dly <= w_is_long ? c_long_m1 : c_short_m1;
        end else if (r_dly != '0) begin
            r_dly <= r_dly - DLY_W'(1);
        end
    end

    assign lcd_start  = (r_state == ST_START);
    assign lcd_data   = r_lcd_data;
    assign lcd_rs     = r_lcd_rs;
    assign fifo_count = r_count;

`ifdef LCD_POWERUP_INIT_EN
    // Reset parks the FSM in PWR_WAIT; keep busy low while reset is held.
    assign busy = rst && ((r_state != ST_IDLE) || (r_count != '0) || w_init_active);
`else
    assign busy = (r_state != ST_IDLE) || (r_count != '0);
`endif

endmodule
`default_nettype wire
